// File: rtl/oled_spi_sink.sv
// rtl/oled_spi_sink.sv - SPI OLED controller sink decoding column/row windows and RGB565 pixel writes
module oled_spi_sink #(
    parameter int C_X_BITS = 7,
    parameter int C_Y_BITS = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                spi_csn,
    input  logic                spi_clk,
    input  logic                spi_mosi,
    input  logic                spi_dc,
    input  logic                spi_resn,
    output logic [C_X_BITS-1:0] x,
    output logic [C_Y_BITS-1:0] y,
    output logic [15:0]         color,
    output logic                pixel_we,
    output logic                cmd_valid,
    output logic [7:0]          cmd_byte
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PARAM = 2'd1;
    localparam logic [1:0] ST_RAM   = 2'd2;

    localparam logic [7:0] CMD_COL = 8'h15;
    localparam logic [7:0] CMD_ROW = 8'h75;
    localparam logic [7:0] CMD_RAM = 8'h5C;

    localparam logic [C_X_BITS-1:0] X_ONE = 1;
    localparam logic [C_Y_BITS-1:0] Y_ONE = 1;

    logic [1:0] csn_sync, sclk_sync, mosi_sync, dc_sync, resn_sync;
    logic       sclk_prev;
    logic       csn_s, mosi_s, dc_s, resn_s, sclk_rise;

    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_dc;

    logic [1:0]          state;
    logic                param_row;
    logic                param_idx;
    logic                pix_low;
    logic [7:0]          hi_byte;
    logic                adv_pending;
    logic [C_X_BITS-1:0] col_start, col_end;
    logic [C_Y_BITS-1:0] row_start, row_end;

    assign csn_s     = csn_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign dc_s      = dc_sync[1];
    assign resn_s    = resn_sync[1];
    assign sclk_rise = sclk_sync[1] & ~sclk_prev;

    // Two-flop synchronizers for all SPI pins plus the spi_clk edge-detect history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csn_sync  <= 2'b11;
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            dc_sync   <= 2'b00;
            resn_sync <= 2'b11;
            sclk_prev <= 1'b0;
        end else begin
            csn_sync  <= {csn_sync[0], spi_csn};
            sclk_sync <= {sclk_sync[0], spi_clk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            dc_sync   <= {dc_sync[0], spi_dc};
            resn_sync <= {resn_sync[0], spi_resn};
            sclk_prev <= sclk_sync[1];
        end
    end

    // Byte assembly: MSB-first shift on each spi_clk rise; deselect drops any partial byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg  <= 8'h00;
            bit_cnt    <= 3'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            byte_dc    <= 1'b0;
        end else if (!resn_s) begin
            shift_reg  <= 8'h00;
            bit_cnt    <= 3'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            byte_dc    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (csn_s) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                shift_reg <= {shift_reg[6:0], mosi_s};
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shift_reg[6:0], mosi_s};
                    byte_dc    <= dc_s;
                end
            end
        end
    end

    // Command/parameter FSM, pixel assembly and window-bounded cursor advance
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            param_row   <= 1'b0;
            param_idx   <= 1'b0;
            pix_low     <= 1'b0;
            hi_byte     <= 8'h00;
            adv_pending <= 1'b0;
            col_start   <= '0;
            col_end     <= '1;
            row_start   <= '0;
            row_end     <= '1;
            x           <= '0;
            y           <= '0;
            color       <= 16'h0000;
            pixel_we    <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_byte    <= 8'h00;
        end else if (!resn_s) begin
            state       <= ST_IDLE;
            param_row   <= 1'b0;
            param_idx   <= 1'b0;
            pix_low     <= 1'b0;
            hi_byte     <= 8'h00;
            adv_pending <= 1'b0;
            col_start   <= '0;
            col_end     <= '1;
            row_start   <= '0;
            row_end     <= '1;
            x           <= '0;
            y           <= '0;
            color       <= 16'h0000;
            pixel_we    <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_byte    <= 8'h00;
        end else begin
            pixel_we  <= 1'b0;
            cmd_valid <= 1'b0;

            // Cursor moves one clk after the write so x/y stay valid during pixel_we
            if (adv_pending) begin
                adv_pending <= 1'b0;
                if (x == col_end) begin
                    x <= col_start;
                    if (y == row_end) begin
                        y <= row_start;
                    end else begin
                        y <= y + Y_ONE;
                    end
                end else begin
                    x <= x + X_ONE;
                end
            end

            if (byte_valid) begin
                if (!byte_dc) begin
                    cmd_valid <= 1'b1;
                    cmd_byte  <= byte_data;
                    pix_low   <= 1'b0;
                    param_idx <= 1'b0;
                    case (byte_data)
                        CMD_COL: begin
                            state     <= ST_PARAM;
                            param_row <= 1'b0;
                        end
                        CMD_ROW: begin
                            state     <= ST_PARAM;
                            param_row <= 1'b1;
                        end
                        CMD_RAM: begin
                            state       <= ST_RAM;
                            x           <= col_start;
                            y           <= row_start;
                            adv_pending <= 1'b0;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end else begin
                    case (state)
                        ST_PARAM: begin
                            param_idx <= ~param_idx;
                            if (!param_idx) begin
                                if (param_row) row_start <= C_Y_BITS'(byte_data[6:0]);
                                else           col_start <= C_X_BITS'(byte_data[6:0]);
                            end else begin
                                if (param_row) row_end <= C_Y_BITS'(byte_data[6:0]);
                                else           col_end <= C_X_BITS'(byte_data[6:0]);
                                state <= ST_IDLE;
                            end
                        end
                        ST_RAM: begin
                            if (!pix_low) begin
                                hi_byte <= byte_data;
                                pix_low <= 1'b1;
                            end else begin
                                color       <= {hi_byte, byte_data};
                                pixel_we    <= 1'b1;
                                pix_low     <= 1'b0;
                                adv_pending <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_oled_spi_sink.sv
// tb/tb_oled_spi_sink.sv - directed self-checking bench for oled_spi_sink
module tb_oled_spi_sink;

    logic        clk;
    logic        reset;
    logic        spi_csn, spi_clk, spi_mosi, spi_dc, spi_resn;
    logic [6:0]  x, y;
    logic [15:0] color;
    logic        pixel_we, cmd_valid;
    logic [7:0]  cmd_byte;

    int n_total = 0;
    int n_pass  = 0;

    logic [29:0] pixq[$];
    logic [7:0]  cmdq[$];

    oled_spi_sink #(.C_X_BITS(7), .C_Y_BITS(7)) dut (
        .clk      (clk),
        .reset    (reset),
        .spi_csn  (spi_csn),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_dc   (spi_dc),
        .spi_resn (spi_resn),
        .x        (x),
        .y        (y),
        .color    (color),
        .pixel_we (pixel_we),
        .cmd_valid(cmd_valid),
        .cmd_byte (cmd_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record strobes away from the active edge
    always @(negedge clk) begin
        if (pixel_we)  pixq.push_back({x, y, color});
        if (cmd_valid) cmdq.push_back(cmd_byte);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        spi_mosi = b;
        spi_clk  = 1'b0;
        wait_clks(2);
        spi_clk = 1'b1;
        wait_clks(2);
        spi_clk = 1'b0;
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] b);
        spi_dc = dc;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic send_pixel(input logic [15:0] c);
        send_byte(1'b1, c[15:8]);
        send_byte(1'b1, c[7:0]);
    endtask

    task automatic set_window(input logic [7:0] cs, input logic [7:0] ce,
                              input logic [7:0] rs, input logic [7:0] re);
        send_byte(1'b0, 8'h15);
        send_byte(1'b1, cs);
        send_byte(1'b1, ce);
        send_byte(1'b0, 8'h75);
        send_byte(1'b1, rs);
        send_byte(1'b1, re);
    endtask

    task automatic expect_pix(input string tag, input logic [6:0] xe, input logic [6:0] ye,
                              input logic [15:0] ce);
        logic [29:0] g;
        g = (pixq.size() > 0) ? pixq.pop_front() : 30'h3fffffff;
        chk(tag, {2'b00, g}, {2'b00, xe, ye, ce});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_x"}, {25'd0, x}, 32'd0);
        chk({tag, "_y"}, {25'd0, y}, 32'd0);
        chk({tag, "_color"}, {16'd0, color}, 32'd0);
        chk({tag, "_we"}, {31'd0, pixel_we}, 32'd0);
        chk({tag, "_cv"}, {31'd0, cmd_valid}, 32'd0);
        chk({tag, "_cmd"}, {24'd0, cmd_byte}, 32'd0);
    endtask

    logic [6:0] ex2 [5] = '{7'd2, 7'd3, 7'd2, 7'd3, 7'd2};
    logic [6:0] ey2 [5] = '{7'd5, 7'd5, 7'd6, 7'd6, 7'd5};
    logic [6:0] ex5 [5] = '{7'd126, 7'd127, 7'd126, 7'd127, 7'd126};
    logic [6:0] ey5 [5] = '{7'd126, 7'd126, 7'd127, 7'd127, 7'd126};
    logic [6:0] ex6 [9] = '{7'd126, 7'd127, 7'd0, 7'd1, 7'd126, 7'd127, 7'd0, 7'd1, 7'd126};
    logic [6:0] ey6 [9] = '{7'd127, 7'd127, 7'd127, 7'd127, 7'd0, 7'd0, 7'd0, 7'd0, 7'd127};

    initial begin
        reset = 1'b1; spi_csn = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        spi_dc = 1'b0; spi_resn = 1'b1;
        wait_clks(3);
        check_reset_outputs("rst");
        reset = 1'b0;
        wait_clks(4);
        spi_csn = 1'b0;
        wait_clks(4);

        // Single red pixel at origin
        send_byte(1'b0, 8'h5C);
        send_pixel(16'hF800);
        wait_clks(10);
        chk("single_count", pixq.size(), 1);
        expect_pix("single_pix", 7'd0, 7'd0, 16'hF800);
        chk("single_cmdn", cmdq.size(), 1);
        chk("single_cmd", {24'd0, cmdq.pop_front()}, 32'h5C);
        send_pixel(16'h1111);
        send_pixel(16'h2222);
        wait_clks(10);
        expect_pix("dflt_p1", 7'd1, 7'd0, 16'h1111);
        expect_pix("dflt_p2", 7'd2, 7'd0, 16'h2222);

        // 2x2 window with wrap back to start
        set_window(8'd2, 8'd3, 8'd5, 8'd6);
        send_byte(1'b0, 8'h5C);
        for (int i = 0; i < 5; i++) send_pixel(16'h1000 + 16'(i));
        wait_clks(10);
        chk("win_count", pixq.size(), 5);
        for (int i = 0; i < 5; i++)
            expect_pix($sformatf("win_p%0d", i), ex2[i], ey2[i], 16'h1000 + 16'(i));

        // Deselect mid-byte drops the partial bits only
        send_byte(1'b0, 8'h5C);
        send_byte(1'b1, 8'hAB);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        spi_csn = 1'b1;
        wait_clks(4);
        spi_csn = 1'b0;
        wait_clks(2);
        send_byte(1'b1, 8'hCD);
        wait_clks(10);
        chk("csn_count", pixq.size(), 1);
        expect_pix("csn_pix", 7'd2, 7'd5, 16'hABCD);

        // Command mid-pixel discards it; unknown command leaves data ignored
        cmdq.delete();
        send_byte(1'b0, 8'h5C);
        send_byte(1'b1, 8'h12);
        send_byte(1'b0, 8'hAF);
        send_byte(1'b1, 8'h34);
        send_byte(1'b1, 8'h56);
        wait_clks(10);
        chk("abort_nopix", pixq.size(), 0);
        chk("abort_cmdn", cmdq.size(), 2);
        chk("abort_last", {24'd0, cmdq[cmdq.size()-1]}, 32'hAF);
        chk("abort_cmdbyte", {24'd0, cmd_byte}, 32'hAF);
        send_byte(1'b0, 8'h5C);
        send_pixel(16'h7777);
        wait_clks(10);
        expect_pix("abort_after", 7'd2, 7'd5, 16'h7777);

        // Window at panel edge: 127 is the last column/row
        set_window(8'd126, 8'd127, 8'd126, 8'd127);
        send_byte(1'b0, 8'h5C);
        for (int i = 0; i < 5; i++) send_pixel(16'h5000 + 16'(i));
        wait_clks(10);
        for (int i = 0; i < 5; i++)
            expect_pix($sformatf("edge_p%0d", i), ex5[i], ey5[i], 16'h5000 + 16'(i));

        // start > end: count up through 127 -> 0 until end, then back to start
        set_window(8'd126, 8'd1, 8'd127, 8'd0);
        send_byte(1'b0, 8'h5C);
        for (int i = 0; i < 9; i++) send_pixel(16'h6000 + 16'(i));
        wait_clks(10);
        chk("inv_count", pixq.size(), 9);
        for (int i = 0; i < 9; i++)
            expect_pix($sformatf("inv_p%0d", i), ex6[i], ey6[i], 16'h6000 + 16'(i));

        // Asynchronous reset mid-stream
        send_byte(1'b0, 8'h5C);
        send_pixel(16'h9999);
        send_byte(1'b1, 8'hAA);
        wait_clks(10);
        pixq.delete();
        reset = 1'b1;
        #1;
        check_reset_outputs("arst");
        @(negedge clk);
        reset = 1'b0;
        wait_clks(4);
        send_byte(1'b0, 8'h5C);
        for (int i = 0; i < 3; i++) send_pixel(16'h3000 + 16'(i));
        wait_clks(10);
        for (int i = 0; i < 3; i++)
            expect_pix($sformatf("post_rst_p%0d", i), 7'(i), 7'd0, 16'h3000 + 16'(i));

        // Panel reset via spi_resn mid-pixel
        set_window(8'd10, 8'd20, 8'd30, 8'd40);
        send_byte(1'b0, 8'h5C);
        send_pixel(16'h8888);
        send_byte(1'b1, 8'hAB);
        wait_clks(10);
        expect_pix("resn_pre", 7'd10, 7'd30, 16'h8888);
        spi_resn = 1'b0;
        wait_clks(3);
        check_reset_outputs("resn");
        spi_resn = 1'b1;
        wait_clks(4);
        send_byte(1'b0, 8'h5C);
        send_pixel(16'h4321);
        wait_clks(10);
        chk("resn_count", pixq.size(), 1);
        expect_pix("resn_post", 7'd0, 7'd0, 16'h4321);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/oled_spi_sink.md
OLED_SPI_SINK -- requirements
Module: oled_spi_sink

Interface
REQ-001 C_X_BITS, default 7, width of the x cursor (128-column panel).
REQ-002 C_Y_BITS, default 7, width of the y cursor (128-row panel).
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 spi_csn  input  1  SPI chip select, active low; asynchronous to clk.
REQ-006 spi_clk  input  1  SPI clock, mode 0 (idle high tolerated); MSB first.
REQ-007 spi_mosi  input  1  serial data, sampled on spi_clk rising edge.
REQ-008 spi_dc  input  1  0 = command byte, 1 = data byte; sampled with bit 0 of each byte.
REQ-009 spi_resn  input  1  panel reset, active low.
REQ-010 x  output  C_X_BITS  column of the current pixel write.
REQ-011 y  output  C_Y_BITS  row of the current pixel write.
REQ-012 color  output  16  RGB565 pixel value.
REQ-013 pixel_we  output  1  one-clk strobe; x, y and color are valid while it is high.
REQ-014 cmd_valid  output  1  one-clk strobe when a command byte completes.
REQ-015 cmd_byte  output  8  last received command byte.

Function
REQ-016 spi_csn, spi_clk, spi_mosi, spi_dc and spi_resn SHALL each pass through a 2-flop synchronizer; the clk frequency SHALL be at least 4x the spi_clk frequency.
REQ-017 Each synchronized spi_clk 0->1 transition while spi_csn=0 SHALL shift spi_mosi into an 8-bit shift register, MSB first, and increment a 3-bit bit counter.
REQ-018 spi_csn=1 SHALL clear the bit counter and discard any partial byte; FSM state, window and cursor SHALL be retained.
REQ-019 On the 8th bit, the module SHALL complete the byte with dc equal to spi_dc sampled on that same edge, and process the byte on the following clk.
REQ-020 The FSM states SHALL be IDLE, PARAM and RAM.
REQ-021 A command byte (dc=0) SHALL, in any state, pulse cmd_valid for 1 clk and load cmd_byte.
REQ-022 Command 0x15 SHALL enter PARAM expecting 2 bytes: column start, then column end.
REQ-023 Command 0x75 SHALL enter PARAM expecting 2 bytes: row start, then row end.
REQ-024 Command 0x5C SHALL enter RAM, set x=col_start, y=row_start and set the pixel phase to the high byte.
REQ-025 Any other command SHALL enter IDLE; following data bytes SHALL be ignored.
REQ-026 In PARAM, each data byte SHALL store bits [6:0] of the byte; after the 2nd byte the FSM SHALL return to IDLE.
REQ-027 In RAM, a data byte in the high phase SHALL be latched as color[15:8]; the next data byte SHALL form color[7:0].
REQ-028 On the low byte, pixel_we SHALL pulse for 1 clk carrying the current x, y and the full color; the cursor SHALL advance on the next clk.
REQ-029 Cursor advance: if x==col_end, x SHALL become col_start; otherwise x SHALL become x+1 mod 128.
REQ-030 On that x wrap, y SHALL advance the same way: if y==row_end, y SHALL become row_start; otherwise y+1 mod 128.
REQ-031 If start>end, the counter SHALL still increment mod 128 until it equals end, then wrap to start.
REQ-032 A command byte arriving mid-pixel (after a high byte only) SHALL discard the partial pixel.
REQ-033 Synchronized spi_resn=0 SHALL apply the reset state of REQ-034 except the synchronizers themselves.

Reset
REQ-034 reset=1 SHALL asynchronously force:
- pixel_we=0, cmd_valid=0, cmd_byte=0x00, x=0, y=0, color=0x0000
- FSM=IDLE, bit counter=0, col window 0..127, row window 0..127, pixel phase=high.

Verification
REQ-035 Sequence cmd 0x5C, data 0xF8,0x00 -> exactly one pixel_we with x=0, y=0, color=0xF800.
REQ-036 Sequence cmd 0x15, data 2,3; cmd 0x75, data 5,6; cmd 0x5C; 5 pixels -> writes at (2,5),(3,5),(2,6),(3,6), then (2,5).
REQ-037 Default window, 128x128 pixels streamed -> last write at (127,127); the next pixel lands at (0,0).
REQ-038 cmd 0x5C, data 0xAB, spi_csn pulses high for 3 bits of a byte, then data 0xCD -> pixel color=0xABCD; the partial byte is dropped.
REQ-039 cmd 0x5C, data 0x12, then cmd 0xAF -> no pixel_we; cmd_valid=1 with cmd_byte=0xAF; FSM=IDLE.
REQ-040 reset or spi_resn pulse during RAM streaming -> outputs return to REQ-034 values within 1 clk (reset) or 3 clks (spi_resn).
